// File: rtl/adc_scan_sched_pkg.sv
// Shared types and helpers for the ADC channel scan scheduler.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } state_t;

    localparam int unsigned CH_BITS_DEF    = 5;
    localparam int unsigned NUM_OF_ADC_DEF = 4;

    // Widest channel mask the helper accepts; callers zero-extend narrower masks.
    localparam int unsigned MAX_CH_BITS = 8;
    localparam int unsigned MAX_CH      = 2 ** MAX_CH_BITS;

    typedef struct packed {
        logic                   found;
        logic [MAX_CH_BITS-1:0] idx;
    } low_t;

    // Index of the lowest set bit; idx is 0 and found is 0 for an empty mask.
    function automatic low_t lowest_set(input logic [MAX_CH-1:0] mask);
        low_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (mask[i] && !r.found) begin
                r.found = 1'b1;
                r.idx   = MAX_CH_BITS'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_scan_sched_if.sv
// Merged sample stream handshake as seen by the scan scheduler (monitor only).
interface adc_scan_sched_if #(
    parameter int unsigned ID_BITS = 3
);
    logic               smp_valid;
    logic               smp_ready;
    logic [ID_BITS-1:0] smp_adc;

    modport master (output smp_valid, output smp_ready, output smp_adc);
    modport slave  (input  smp_valid, input  smp_ready, input  smp_adc);
endinterface

// File: rtl/adc_scan_sched_next_ch_find.sv
// Combinational search for the next enabled channel above the current one.
module next_ch_find
    import adc_sched_pkg::*;
#(
    parameter int unsigned CH_BITS = CH_BITS_DEF
) (
    input  logic [2**CH_BITS-1:0] mask,
    input  logic [CH_BITS-1:0]    cur,
    output logic [CH_BITS-1:0]    nxt,
    output logic [CH_BITS-1:0]    low,
    output logic                  wrap,
    output logic                  empty
);
    localparam int unsigned NCH = 2 ** CH_BITS;

    logic [MAX_CH-1:0] ext;
    low_t              lo;
    logic              above;

    // Lowest enabled channel, and first enabled channel strictly above cur.
    always_comb begin
        ext          = '0;
        ext[NCH-1:0] = mask;
        lo           = lowest_set(ext);
        low          = CH_BITS'(lo.idx);
        empty        = ~lo.found;
        nxt          = CH_BITS'(lo.idx);
        above        = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (mask[i] && !above && (i > 32'(cur))) begin
                above = 1'b1;
                nxt   = CH_BITS'(i);
            end
        end
        wrap = ~above;
    end

endmodule

// File: rtl/adc_scan_sched.sv
// Channel scan scheduler: walks each ADC through its enabled-channel list,
// one step per accepted sample, counts full scans and flags a stalled stream.
module adc_scan_sched
    import adc_sched_pkg::*;
#(
    parameter int unsigned NUM_OF_ADC     = NUM_OF_ADC_DEF,
    parameter int unsigned CH_BITS        = CH_BITS_DEF,
    parameter int unsigned ID_BITS        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2**CH_BITS-1:0] ch_mask [0:NUM_OF_ADC-1],
    adc_scan_sched_if.slave       smp,
    output logic [CH_BITS-1:0]    sel [0:NUM_OF_ADC-1],
    output logic                  busy,
    output logic                  scan_done,
    output logic [CNT_WIDTH-1:0]  scan_count,
    output logic                  timeout_err
);
    localparam int unsigned NCH  = 2 ** CH_BITS;
    localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [NCH-1:0]        mask_q    [0:NUM_OF_ADC-1];
    logic [CH_BITS-1:0]    start_sel [0:NUM_OF_ADC-1];
    logic [CH_BITS-1:0]    nxt_ch    [0:NUM_OF_ADC-1];
    logic [CH_BITS-1:0]    low_ch    [0:NUM_OF_ADC-1];
    logic [NUM_OF_ADC-1:0] wrap, empty, step, wrapped, wr_next;
    logic [TW-1:0]         tcnt;
    logic [ID_BITS-1:0]    adc_id;
    logic                  acc, all_done;
    logic                  do_load, do_run, do_err, do_stop;
    logic [MAX_CH-1:0]     ext;
    low_t                  lo;

    assign adc_id = smp.smp_adc;
    assign acc    = smp.smp_valid & smp.smp_ready;

    for (genvar g = 0; g < NUM_OF_ADC; g++) begin : g_find
        next_ch_find #(.CH_BITS(CH_BITS)) u_find (
            .mask  (mask_q[g]),
            .cur   (sel[g]),
            .nxt   (nxt_ch[g]),
            .low   (low_ch[g]),
            .wrap  (wrap[g]),
            .empty (empty[g])
        );
    end

    // Per-ADC step decode, start channels from the live mask, scan completion.
    // Empty-mask ADCs are folded into wr_next so they never block completion.
    always_comb begin
        ext = '0;
        lo  = '0;
        for (int unsigned k = 0; k < NUM_OF_ADC; k++) begin
            step[k]      = acc && (32'(adc_id) == k) && !empty[k];
            ext          = '0;
            ext[NCH-1:0] = ch_mask[k];
            lo           = lowest_set(ext);
            start_sel[k] = lo.found ? CH_BITS'(lo.idx) : '0;
        end
        wr_next  = wrapped | (step & wrap) | empty;
        all_done = (&wr_next) && !(&empty);
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_run  = 1'b0;
        do_err  = 1'b0;
        do_stop = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    do_load = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    do_stop = 1'b1;
                end else begin
                    do_run = 1'b1;
                    if (!acc && (tcnt == TMAX)) begin
                        state_d = ERR;
                        do_err  = 1'b1;
                    end
                end
            end
            ERR: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, channel selects, wrap tracking, timeout and scan counters.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
            scan_count  <= '0;
            timeout_err <= 1'b0;
            wrapped     <= '0;
            tcnt        <= '0;
            for (int unsigned k = 0; k < NUM_OF_ADC; k++) begin
                sel[k]    <= '0;
                mask_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            busy      <= (state_d == RUN);
            scan_done <= 1'b0;
            if (do_load) begin
                mask_q      <= ch_mask;
                sel         <= start_sel;
                wrapped     <= '0;
                scan_count  <= '0;
                tcnt        <= '0;
                timeout_err <= 1'b0;
            end
            if (do_run) begin
                tcnt <= acc ? '0 : tcnt + TW'(1);
                for (int unsigned k = 0; k < NUM_OF_ADC; k++) begin
                    if (step[k]) sel[k] <= wrap[k] ? low_ch[k] : nxt_ch[k];
                end
                if (all_done) begin
                    wrapped    <= '0;
                    scan_done  <= 1'b1;
                    scan_count <= scan_count + CNT_WIDTH'(1);
                end else begin
                    wrapped <= wr_next;
                end
            end
            if (do_err)  timeout_err <= 1'b1;
            if (do_stop) wrapped     <= '0;
        end
    end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Directed self-checking bench for adc_scan_sched (4 ADCs, 32 channels, timeout 16).
module tb_adc_scan_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] ch_mask [0:N-1];
    logic [4:0]  sel     [0:N-1];
    logic [4:0]  e       [0:N-1];
    logic        busy, scan_done, timeout_err;
    logic [15:0] scan_count;
    int          n_checks = 0;
    int          n_fail   = 0;

    adc_scan_sched_if #(.ID_BITS(3)) smp_if ();

    adc_scan_sched #(
        .NUM_OF_ADC     (N),
        .CH_BITS        (5),
        .ID_BITS        (3),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (16)
    ) dut (
        .CLK         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .smp         (smp_if),
        .sel         (sel),
        .busy        (busy),
        .scan_done   (scan_done),
        .scan_count  (scan_count),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        enable           = 1'b0;
        smp_if.smp_valid = 1'b0;
        smp_if.smp_ready = 1'b1;
        smp_if.smp_adc   = '0;
        for (int k = 0; k < N; k++) ch_mask[k] = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input logic [31:0] m0, m1, m2, m3);
        ch_mask[0] = m0;
        ch_mask[1] = m1;
        ch_mask[2] = m2;
        ch_mask[3] = m3;
        enable     = 1'b1;
        tick();
    endtask

    task automatic sample(input int a);
        smp_if.smp_adc   = 3'(a);
        smp_if.smp_valid = 1'b1;
        smp_if.smp_ready = 1'b1;
        tick();
        smp_if.smp_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (sel[k] !== 5'd0) begin
                n_fail++;
                $display("FAIL reset_sel%0d: got %0d expected 0", k, sel[k]);
            end
        end
        n_checks++;
        if ({busy, scan_done, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {busy, scan_done, timeout_err});
        end
        n_checks++;
        if (scan_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", scan_count);
        end
    endtask

    task automatic test_scan_walk();
        do_reset();
        start(32'h0000_0005, 32'h8000_0001, 32'h0000_0010, 32'h0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL walk_busy: got %b expected 1", busy);
        end
        e = '{5'd0, 5'd0, 5'd4, 5'd0};
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (sel[k] !== e[k]) begin
                n_fail++;
                $display("FAIL walk_start_sel%0d: got %0d expected %0d", k, sel[k], e[k]);
            end
        end
        // valid without ready is not an accepted sample
        smp_if.smp_adc   = 3'd0;
        smp_if.smp_valid = 1'b1;
        smp_if.smp_ready = 1'b0;
        tick();
        smp_if.smp_valid = 1'b0;
        smp_if.smp_ready = 1'b1;
        n_checks++;
        if (sel[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL walk_noready: got %0d expected 0", sel[0]);
        end
        sample(0);
        n_checks++;
        if (sel[0] !== 5'd2) begin
            n_fail++;
            $display("FAIL walk_adc0_step: got %0d expected 2", sel[0]);
        end
        sample(0);
        n_checks++;
        if ({sel[0], scan_done} !== {5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL walk_adc0_wrap: got sel %0d done %b expected sel 0 done 0", sel[0], scan_done);
        end
        sample(1);
        n_checks++;
        if (sel[1] !== 5'd31) begin
            n_fail++;
            $display("FAIL walk_adc1_step: got %0d expected 31", sel[1]);
        end
        sample(1);
        n_checks++;
        if ({sel[1], scan_done} !== {5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL walk_adc1_wrap: got sel %0d done %b expected sel 0 done 0", sel[1], scan_done);
        end
        sample(2);
        n_checks++;
        if ({sel[2], scan_done, scan_count} !== {5'd4, 1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL walk_done: got sel %0d done %b count %0d expected sel 4 done 1 count 1",
                     sel[2], scan_done, scan_count);
        end
        tick();
        n_checks++;
        if ({scan_done, scan_count} !== {1'b0, 16'd1}) begin
            n_fail++;
            $display("FAIL walk_done_pulse: got done %b count %0d expected done 0 count 1", scan_done, scan_count);
        end
    endtask

    task automatic test_enable_stop();
        do_reset();
        start(32'h0000_0005, 32'h8000_0001, 32'h0000_0010, 32'h0);
        sample(0);
        sample(0);
        sample(1);
        sample(1);
        sample(2);
        sample(0);
        enable = 1'b0;
        tick();
        n_checks++;
        if ({busy, sel[0], sel[2], scan_count} !== {1'b0, 5'd2, 5'd4, 16'd1}) begin
            n_fail++;
            $display("FAIL stop_hold: got busy %b sel0 %0d sel2 %0d count %0d expected 0 2 4 1",
                     busy, sel[0], sel[2], scan_count);
        end
        sample(0);
        tick();
        n_checks++;
        if ({busy, sel[0]} !== {1'b0, 5'd2}) begin
            n_fail++;
            $display("FAIL stop_idle_sample: got busy %b sel0 %0d expected busy 0 sel0 2", busy, sel[0]);
        end
    endtask

    task automatic test_mask_change();
        do_reset();
        start(32'h0000_0005, 32'h8000_0001, 32'h0000_0010, 32'h0);
        ch_mask[0] = 32'h0000_0008;
        sample(0);
        n_checks++;
        if (sel[0] !== 5'd2) begin
            n_fail++;
            $display("FAIL mask_live_step: got %0d expected 2", sel[0]);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        n_checks++;
        if ({busy, sel[0], scan_count} !== {1'b1, 5'd3, 16'd0}) begin
            n_fail++;
            $display("FAIL mask_reload: got busy %b sel0 %0d count %0d expected 1 3 0", busy, sel[0], scan_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start(32'h0000_0100, 32'h0, 32'h0, 32'h0);
        n_checks++;
        if (sel[0] !== 5'd8) begin
            n_fail++;
            $display("FAIL b2b_start: got %0d expected 8", sel[0]);
        end
        smp_if.smp_adc   = 3'd0;
        smp_if.smp_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if ({sel[0], scan_done, scan_count} !== {5'd8, 1'b1, 16'(i)}) begin
                n_fail++;
                $display("FAIL b2b_pulse%0d: got sel %0d done %b count %0d expected sel 8 done 1 count %0d",
                         i, sel[0], scan_done, scan_count, i);
            end
        end
        smp_if.smp_valid = 1'b0;
        tick();
        n_checks++;
        if ({scan_done, scan_count} !== {1'b0, 16'd3}) begin
            n_fail++;
            $display("FAIL b2b_end: got done %b count %0d expected done 0 count 3", scan_done, scan_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start(32'h0000_0005, 32'h8000_0001, 32'h0000_0010, 32'h0);
        repeat (TO - 1) tick();
        n_checks++;
        if ({busy, timeout_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_early: got busy %b err %b expected busy 1 err 0", busy, timeout_err);
        end
        tick();
        n_checks++;
        if ({busy, timeout_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_rise: got busy %b err %b expected busy 0 err 1", busy, timeout_err);
        end
        sample(0);
        n_checks++;
        if (sel[0] !== 5'd0) begin
            n_fail++;
            $display("FAIL tmo_err_sample: got %0d expected 0", sel[0]);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if ({busy, timeout_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL tmo_sticky: got busy %b err %b expected busy 0 err 1", busy, timeout_err);
        end
        ch_mask[0] = 32'h0000_0008;
        enable     = 1'b1;
        tick();
        n_checks++;
        if ({busy, timeout_err, sel[0], sel[2]} !== {1'b1, 1'b0, 5'd3, 5'd4}) begin
            n_fail++;
            $display("FAIL tmo_restart: got busy %b err %b sel0 %0d sel2 %0d expected 1 0 3 4",
                     busy, timeout_err, sel[0], sel[2]);
        end
    endtask

    task automatic test_bad_id();
        do_reset();
        start(32'h0000_0005, 32'h8000_0001, 32'h0000_0010, 32'h0);
        repeat (10) tick();
        sample(5);
        e = '{5'd0, 5'd0, 5'd4, 5'd0};
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if (sel[k] !== e[k]) begin
                n_fail++;
                $display("FAIL badid_sel%0d: got %0d expected %0d", k, sel[k], e[k]);
            end
        end
        repeat (TO - 1) tick();
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL badid_tmo_clear: got err %b expected 0", timeout_err);
        end
        repeat (2) tick();
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL badid_tmo_late: got err %b expected 1", timeout_err);
        end
    endtask

    task automatic test_empty_masks();
        do_reset();
        start(32'h0, 32'h0, 32'h0, 32'h0);
        for (int a = 0; a < N; a++) begin
            sample(a);
            n_checks++;
            if ({busy, scan_done, sel[0], sel[1], sel[2], sel[3]} !== {1'b1, 1'b0, 20'd0}) begin
                n_fail++;
                $display("FAIL empty_adc%0d: got busy %b done %b sel %0d %0d %0d %0d expected 1 0 0 0 0 0",
                         a, busy, scan_done, sel[0], sel[1], sel[2], sel[3]);
            end
        end
    endtask

    task automatic test_rst_run();
        do_reset();
        start(32'h0000_0100, 32'h0, 32'h0, 32'h0);
        smp_if.smp_adc   = 3'd0;
        smp_if.smp_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({busy, scan_done, timeout_err, sel[0], scan_count} !== {3'b000, 5'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL rst_run: got busy %b done %b err %b sel0 %0d count %0d expected all 0",
                     busy, scan_done, timeout_err, sel[0], scan_count);
        end
        rst              = 1'b0;
        smp_if.smp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_walk();
        test_enable_stop();
        test_mask_change();
        test_back_to_back();
        test_timeout();
        test_bad_id();
        test_empty_masks();
        test_rst_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
